// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared definitions for the video capture path and the display path:
//   the 640x480 timing constants and the capture FSM state type.
package vga_pkg;

  localparam int HACTIVE = 640;
  localparam int HFP     = 16;
  localparam int HSYN    = 96;
  localparam int HBP     = 48;
  localparam int VACTIVE = 480;
  localparam int VFP     = 10;
  localparam int VSYN    = 2;
  localparam int VBP     = 33;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_WAIT_FRAME,
    ST_CAPTURE,
    ST_DONE
  } cap_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
//   Remembers the last qualified value of one input and flags qualified
//   rising / falling transitions against it. Samples with i_en=0 are not
//   stored and never produce an edge.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_en            sample qualifier
//   i_d             input being watched
//   o_rise, o_fall  single-cycle edge flags, valid in the qualified cycle
module sync_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= RST_VAL;
    end else if (i_en) begin
      r_prev <= i_d;
    end
  end

  assign o_rise = i_en &  i_d & ~r_prev;
  assign o_fall = i_en & ~i_d &  r_prev;

endmodule

// File: rtl/video_capture.sv
// video_capture
//   Captures a WIN_W x WIN_H window from the top-left of one video frame
//   into a frame RAM, starting on a frame boundary after a start request.
//   Checks every captured line for HACTIVE active pixels and flags a frame
//   that ends early.
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_pix_en               pixel-rate qualifier for the stream inputs
//   i_vsync                vertical sync, active low
//   i_blank_b              high during active video
//   i_pix[7:0]             pixel intensity
//   i_start                one-cycle capture request (honoured in IDLE only)
//   o_wr_en/addr/data      registered frame-RAM write port
//   o_busy, o_done         status; done is a one-cycle pulse
//   o_frame_err            sticky line-length / early-vsync error
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | waiting for start
// WAIT_VS    | armed, waiting for vsync low
// WAIT_FRAME | inside vsync, waiting for vsync high
// CAPTURE    | counting pixels/lines and writing the window
// DONE       | one-cycle done pulse, back to IDLE
module video_capture #(
  parameter int WIN_W   = 100,
  parameter int WIN_H   = 100,
  parameter int HACTIVE = vga_pkg::HACTIVE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_en,
  input  logic        i_vsync,
  input  logic        i_blank_b,
  input  logic [7:0]  i_pix,
  input  logic        i_start,
  output logic        o_wr_en,
  output logic [13:0] o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_frame_err
);

  import vga_pkg::*;

  localparam logic [9:0]  LP_WIN_W_X = 10'(WIN_W);
  localparam logic [9:0]  LP_WIN_H_Y = 10'(WIN_H);
  localparam logic [9:0]  LP_HACT_X  = 10'(HACTIVE);
  localparam logic [13:0] LP_WIN_W_A = 14'(WIN_W);
  localparam logic [9:0]  LP_X_MAX   = 10'h3FF;

  cap_state_t  r_state, w_state_nxt;
  logic [9:0]  r_x, w_x_nxt;
  logic [9:0]  r_y, w_y_nxt;
  logic [13:0] r_line_base, w_line_base_nxt;
  logic        r_frame_err, w_frame_err_nxt;
  logic        r_wr_en;
  logic [13:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        w_wr;
  logic [13:0] w_wr_addr;

  logic w_unused_bl_rise;
  logic w_bl_fall;
  logic w_vs_rise;
  logic w_vs_fall_unused;

  sync_edge_detect #(.RST_VAL(1'b0)) u_blank_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_pix_en),
    .i_d     (i_blank_b),
    .o_rise  (w_unused_bl_rise),
    .o_fall  (w_bl_fall)
  );

  sync_edge_detect #(.RST_VAL(1'b1)) u_vsync_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_pix_en),
    .i_d     (i_vsync),
    .o_rise  (w_vs_rise),
    .o_fall  (w_vs_fall_unused)
  );

  // Line base advances by WIN_W per line, so the address is an add, not a multiply.
  assign w_wr_addr = r_line_base + {4'd0, r_x};

  always_comb begin
    w_state_nxt     = r_state;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_line_base_nxt = r_line_base;
    w_frame_err_nxt = r_frame_err;
    w_wr            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt     = ST_WAIT_VS;
          w_frame_err_nxt = 1'b0;
        end
      end
      ST_WAIT_VS: begin
        if (i_pix_en && !i_vsync) begin
          w_state_nxt = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        // Every earlier qualified sample here was low, so a qualified high is the rising edge.
        if (w_vs_rise) begin
          w_state_nxt     = ST_CAPTURE;
          w_x_nxt         = '0;
          w_y_nxt         = '0;
          w_line_base_nxt = '0;
        end
      end
      ST_CAPTURE: begin
        if (i_pix_en) begin
          if (!i_vsync) begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = ST_DONE;
          end else if (i_blank_b) begin
            if (r_x != LP_X_MAX) begin
              w_x_nxt = r_x + 10'd1;
            end
            if ((r_x < LP_WIN_W_X) && (r_y < LP_WIN_H_Y)) begin
              w_wr = 1'b1;
            end
          end else if (w_bl_fall) begin
            if (r_x != LP_HACT_X) begin
              w_frame_err_nxt = 1'b1;
            end
            w_x_nxt         = '0;
            w_y_nxt         = r_y + 10'd1;
            w_line_base_nxt = r_line_base + LP_WIN_W_A;
            if ((r_y + 10'd1) == LP_WIN_H_Y) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_line_base <= '0;
      r_frame_err <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_line_base <= w_line_base_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_wr_en     <= w_wr;
      if (w_wr) begin
        r_wr_addr <= w_wr_addr;
        r_wr_data <= i_pix;
      end
    end
  end

  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state == ST_WAIT_VS) || (r_state == ST_WAIT_FRAME) ||
                       (r_state == ST_CAPTURE);
  assign o_done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_video_capture.sv
module tb_video_capture;

  localparam int W  = 12;
  localparam int H  = 10;
  localparam int HA = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pix_en = 1'b0;
  logic        vsync = 1'b1;
  logic        blank_b = 1'b0;
  logic [7:0]  pix = 8'd0;
  logic        start = 1'b0;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done, frame_err;

  video_capture #(.WIN_W(W), .WIN_H(H), .HACTIVE(HA)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_pix_en    (pix_en),
    .i_vsync     (vsync),
    .i_blank_b   (blank_b),
    .i_pix       (pix),
    .i_start     (start),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_busy      (busy),
    .o_done      (done),
    .o_frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int gap;
    int nl;
    int bad_line;
    int bad_len;
    int hook_kind;
    int hook_line;
    int hook_pix;
    int exp_err;
    int exp_last;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t tbl [8];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   last_addr = -1;
  int   gap = 1;
  bit   rand_pix = 1'b0;
  bit   aborted = 1'b0;
  int   hook_kind = 0;
  int   hook_line = -1;
  int   hook_pix = -1;
  logic pe_at_edge = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) pe_at_edge <= pix_en;

  // Scoreboard: every write must follow a qualified sample and match the next expected entry.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_en) begin
      chk("wr_latency", {31'd0, pe_at_edge}, 1);
      chk("wr_expected", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {18'd0, wr_addr}, mon_e.addr);
        chk("wr_data", {24'd0, wr_data}, mon_e.data);
      end
      last_addr = int'(wr_addr);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic vs, input logic bl, input logic [7:0] px);
    for (int i = 0; i < gap; i++) begin
      pix_en = 1'b0;
      vsync = 1'($urandom);
      blank_b = 1'($urandom);
      pix = 8'($urandom);
      @(posedge clk); #1;
    end
    pix_en = 1'b1;
    vsync = vs;
    blank_b = bl;
    pix = px;
    @(posedge clk); #1;
    pix_en = 1'b0;
  endtask

  task automatic pulse_start();
    pix_en = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_hook();
    if (hook_kind == 1) begin
      pulse_start();
    end else if (hook_kind == 2) begin
      pulse_start();
      for (int i = 0; i < 19; i++) begin
        pix_en = 1'b0;
        vsync = 1'($urandom);
        blank_b = 1'($urandom);
        @(posedge clk); #1;
      end
      chk("hold_busy", {31'd0, busy}, 1);
    end else if (hook_kind == 3) begin
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_wr_en", {31'd0, wr_en}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_pending", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      aborted = 1'b1;
    end
  endtask

  task automatic send_line(input int len, input bit cap, input int l);
    logic [7:0] d;
    wr_t e;
    for (int p = 0; p < len; p++) begin
      if (hook_kind != 0 && l == hook_line && p == hook_pix) do_hook();
      d = rand_pix ? 8'($urandom) : (8'(p) ^ 8'(l));
      if (cap && !aborted && l < H && p < W) begin
        e.addr = l * W + p;
        e.data = int'(d);
        exp_q.push_back(e);
      end
      drive(1'b1, 1'b1, d);
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'($urandom));
  endtask

  // Frame = vsync pulse, back porch, nl lines, then vsync going low again.
  task automatic send_frame(input bit cap, input int nl, input int bad_line, input int bad_len);
    int d0;
    bit m_err;
    d0 = done_cnt;
    aborted = 1'b0;
    last_addr = -1;
    m_err = (nl < H);
    for (int l = 0; l < nl && l < H; l++)
      if (l == bad_line && bad_len != HA) m_err = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 8'($urandom));
    for (int l = 0; l < nl; l++) send_line((l == bad_line) ? bad_len : HA, cap, l);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 8'($urandom));
    if (cap) begin
      chk("done_pulses", done_cnt - d0, aborted ? 0 : 1);
      chk("frame_err", {31'd0, frame_err}, (aborted ? 0 : int'(m_err)));
      chk("busy_end", {31'd0, busy}, 0);
    end
    chk("wr_pending", exp_q.size(), 0);
    hook_kind = 0;
  endtask

  initial begin
    int nl, bl, blen;
    tbl[0] = '{1, 12, -1, 0,    0, 0, 0, 0, 119};
    tbl[1] = '{0, 10,  5, 19,   0, 0, 0, 1, 119};
    tbl[2] = '{1,  5, -1, 0,    0, 0, 0, 1, 59};
    tbl[3] = '{2, 10,  0, 1030, 0, 0, 0, 1, 119};
    tbl[4] = '{0, 11, 10, 5,    0, 0, 0, 0, 119};
    tbl[5] = '{0, 10,  9, 21,   0, 0, 0, 1, 119};
    tbl[6] = '{1, 10,  2, 3,    0, 0, 0, 1, 119};
    tbl[7] = '{0, 10, -1, 0,    2, 2, 7, 0, 119};

    #2 rst_n = 1'b0;
    #1;
    chk("reset_wr_en", {31'd0, wr_en}, 0);
    chk("reset_wr_addr", {18'd0, wr_addr}, 0);
    chk("reset_wr_data", {24'd0, wr_data}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_frame_err", {31'd0, frame_err}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, busy}, 0);

    for (int i = 0; i < 8; i++) begin
      gap = tbl[i].gap;
      rand_pix = 1'b0;
      pulse_start();
      chk("start_busy", {31'd0, busy}, 1);
      chk("start_err_clr", {31'd0, frame_err}, 0);
      hook_kind = tbl[i].hook_kind;
      hook_line = tbl[i].hook_line;
      hook_pix = tbl[i].hook_pix;
      send_frame(1'b1, tbl[i].nl, tbl[i].bad_line, tbl[i].bad_len);
      chk("tbl_err", {31'd0, frame_err}, tbl[i].exp_err);
      chk("tbl_last_addr", last_addr, tbl[i].exp_last);
    end

    // Start in the middle of a frame: nothing is written until the next frame.
    gap = 1;
    hook_kind = 1; hook_line = 1; hook_pix = 6;
    send_frame(1'b0, 3, -1, 0);
    chk("midframe_busy", {31'd0, busy}, 1);
    chk("midframe_no_wr", last_addr, -1);
    send_frame(1'b1, H, -1, 0);
    chk("midframe_last_addr", last_addr, (H - 1) * W + W - 1);
    chk("midframe_err", {31'd0, frame_err}, 0);

    // Reset during line 3: writes stop, no done, then a clean recapture.
    gap = 0;
    pulse_start();
    hook_kind = 3; hook_line = 3; hook_pix = 4;
    send_frame(1'b1, H, -1, 0);
    chk("rst_last_addr", last_addr, 3 * W + 3);
    pulse_start();
    send_frame(1'b1, H, -1, 0);
    chk("after_rst_last_addr", last_addr, (H - 1) * W + W - 1);

    // Randomized frames against the frame-level model.
    rand_pix = 1'b1;
    for (int k = 0; k < 12; k++) begin
      gap = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        hook_kind = 1;
        hook_line = $urandom_range(0, 1);
        hook_pix = $urandom_range(0, HA - 1);
        send_frame(1'b0, 2, -1, 0);
      end else begin
        pulse_start();
      end
      nl = $urandom_range(H - 2, H + 2);
      blen = 0;
      bl = -1;
      if ($urandom_range(0, 2) == 0) begin
        bl = $urandom_range(0, H + 1);
        blen = $urandom_range(HA - 2, HA + 2);
      end
      send_frame(1'b1, nl, bl, blen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_capture.md
VIDEO_CAPTURE -- requirements
Module: video_capture

Interface
REQ-001 The parameter list SHALL be: WIN_W, 100, captured window width in pixels.
REQ-002 The parameter list SHALL be: WIN_H, 100, captured window height in lines.
REQ-003 The parameter list SHALL be: HACTIVE, 640, expected active pixels per line.
REQ-004 The port list SHALL be: clk  input  1  system clock; single clock domain.
REQ-005 The port list SHALL be: rst_n  input  1  asynchronous, active-low reset.
REQ-006 The port list SHALL be: pix_en  input  1  pixel-rate qualifier; stream inputs are valid only on clk edges where pix_en=1.
REQ-007 The port list SHALL be: vsync  input  1  vertical sync, active low.
REQ-008 The port list SHALL be: blank_b  input  1  high during active video.
REQ-009 The port list SHALL be: pix  input  8  pixel intensity.
REQ-010 The port list SHALL be: start  input  1  single-cycle pulse requesting capture of one frame window.
REQ-011 The port list SHALL be: wr_en, wr_addr, wr_data  output  1/14/8  frame-RAM write port.
REQ-012 The port list SHALL be: busy, done, frame_err  output  1 each  status signals.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT_VS, WAIT_FRAME, CAPTURE and DONE.
REQ-014 IDLE: on start=1, the block SHALL go to WAIT_VS and clear frame_err; start SHALL be ignored in every other state.
REQ-015 WAIT_VS: when a qualified sample shows vsync=0, the block SHALL go to WAIT_FRAME.
REQ-016 WAIT_FRAME: when a qualified sample shows vsync=1, the block SHALL go to CAPTURE with x=0 and y=0, so capture always begins on a frame boundary.
REQ-017 CAPTURE, on each qualified sample with blank_b=1: the block SHALL increment x; if x<WIN_W and y<WIN_H, it SHALL write pix to address y*WIN_W+x.
REQ-018 CAPTURE, on each qualified 1->0 edge of blank_b: the block SHALL check x==HACTIVE (any mismatch sets frame_err), increment y, and clear x.
REQ-019 When y reaches WIN_H, the block SHALL go to DONE.
REQ-020 CAPTURE: a qualified vsync=0 sample while y<WIN_H SHALL set frame_err and move the block to DONE.
REQ-021 DONE: done SHALL be high for exactly one clk, and the block SHALL return to IDLE on the next clk.
REQ-022 busy SHALL be 1 in WAIT_VS, WAIT_FRAME and CAPTURE, and 0 in IDLE and DONE.
REQ-023 The write port SHALL be registered: wr_en/wr_addr/wr_data assert exactly 1 clk after the qualifying pix_en edge, and wr_en is a 1-clk pulse.
REQ-024 wr_addr SHALL be computed at full width and SHALL never exceed WIN_W*WIN_H-1 (9999).
REQ-025 x SHALL be 10 bits and saturate at 1023; wrap-around is forbidden.
REQ-026 Edge detection SHALL use the previous qualified blank_b and vsync values; samples with pix_en=0 SHALL be ignored entirely.
REQ-027 frame_err SHALL be sticky until the next accepted start.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, x=0 and y=0.
REQ-029 rst_n=0 SHALL asynchronously force wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0 and frame_err=0.
REQ-030 rst_n=0 SHALL asynchronously set the stored previous blank_b to 0 and the stored previous vsync to 1.
REQ-031 Reset mid-capture SHALL abort without issuing any further writes; no done pulse SHALL follow the abort.
REQ-032 Deassertion of rst_n SHALL take effect on the next clk edge.

Structure
REQ-033 Package vga_pkg SHALL hold the capture state typedef enum and the 640x480 timing constants (HACTIVE, HFP, HSYN, HBP, VACTIVE, VFP, VSYN, VBP) shared with the display path.
REQ-034 A single sub-module, sync_edge_detect, SHALL register one qualified input and output rise and fall pulses; video_capture SHALL instantiate it for blank_b and for vsync.
REQ-035 The address multiply SHALL be implemented as an incremental line-base register (add WIN_W per line), not as a multiplier.

Verification
REQ-036 Scenario: start, then a full 640x480 frame with pix=x[7:0]^y[7:0] and pix_en every second clk -> exactly 10000 writes, wr_addr 0..9999 in order, done pulses once, frame_err=0.
REQ-037 Scenario: start asserted mid-frame -> no writes until after the next vsync low->high, then a correct capture.
REQ-038 Scenario: line 5 has 639 active pixels -> frame_err=1 after line 5, capture still completes, and done pulses.
REQ-039 Scenario: vsync goes low after 50 lines -> frame_err=1, done pulses, and the last write is at address 4999.
REQ-040 Scenario: rst_n pulsed low at line 30 -> wr_en=0 immediately, busy=0, and no done pulse; a new start afterwards captures correctly.
REQ-041 Scenario: start pulsed during CAPTURE and pix_en held 0 for 20 clks mid-line -> start has no effect, and there is no x advance and no write while pix_en=0.
